// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive timing engine.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Generic multi-flop synchronizer for a single asynchronous input bit.
module sync_2ff
  import uart_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/baud_generator.sv
// UART receive timing: validates the start bit at half-bit, strobes each data
// bit at mid-bit and pulses finish at mid-stop-bit.
module baud_generator
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic i_sysclk,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_start,
  output logic o_status,
  output logic o_finish,
  output logic o_baud_clk
);

  localparam int DIVISOR = CLK_FREQ / BAUD;
  localparam int HALF    = DIVISOR / 2;
  localparam int CNT_W   = $clog2(DIVISOR);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);

  logic             w_start_s;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_counter;
  logic [CNT_W-1:0] w_counter_next;
  logic [3:0]       r_bit_cnt;
  logic [3:0]       w_bit_cnt_next;
  logic             r_armed;
  logic             w_armed_next;
  logic             r_status;
  logic             r_finish;
  logic             w_finish_next;
  logic             r_baud_clk;
  logic             w_baud_clk_next;

  sync_2ff #(
    .STAGES (SYNC_STAGES)
  ) u_start_sync (
    .i_clk   (i_sysclk),
    .i_reset (i_reset),
    .i_d     (i_start),
    .o_q     (w_start_s)
  );

  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_counter  <= '0;
      r_bit_cnt  <= '0;
      r_armed    <= 1'b0;
      r_status   <= 1'b0;
      r_finish   <= 1'b0;
      r_baud_clk <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_counter  <= w_counter_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_armed    <= w_armed_next;
      r_status   <= (w_state_next != ST_IDLE);
      r_finish   <= w_finish_next;
      r_baud_clk <= w_baud_clk_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_counter_next  = r_counter;
    w_bit_cnt_next  = r_bit_cnt;
    w_armed_next    = r_armed;
    w_finish_next   = 1'b0;
    w_baud_clk_next = 1'b0;

    if (!i_enable) begin
      w_state_next   = ST_IDLE;
      w_counter_next = '0;
      w_bit_cnt_next = '0;
      w_armed_next   = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          // Arming only in IDLE means a held-low line (break) never retriggers.
          if (r_armed && w_start_s) begin
            w_state_next   = ST_START;
            w_counter_next = '0;
            w_armed_next   = 1'b0;
          end else if (!w_start_s) begin
            w_armed_next = 1'b1;
          end
        end

        ST_START: begin
          if (r_counter == CNT_HALF) begin
            w_counter_next = '0;
            w_bit_cnt_next = '0;
            w_state_next   = w_start_s ? ST_DATA : ST_IDLE;
          end else begin
            w_counter_next = r_counter + 1'b1;
          end
        end

        ST_DATA: begin
          if (r_counter == CNT_LAST) begin
            w_baud_clk_next = 1'b1;
            w_counter_next  = '0;
            w_bit_cnt_next  = r_bit_cnt + 1'b1;
            if (r_bit_cnt == BIT_LAST) begin
              w_state_next = ST_STOP;
            end
          end else begin
            w_counter_next = r_counter + 1'b1;
          end
        end

        ST_STOP: begin
          if (r_counter == CNT_LAST) begin
            w_finish_next  = 1'b1;
            w_counter_next = '0;
            w_bit_cnt_next = '0;
            w_state_next   = ST_IDLE;
          end else begin
            w_counter_next = r_counter + 1'b1;
          end
        end

        default: begin
          w_state_next   = ST_IDLE;
          w_counter_next = '0;
          w_bit_cnt_next = '0;
        end
      endcase
    end
  end

  assign o_status   = r_status;
  assign o_finish   = r_finish;
  assign o_baud_clk = r_baud_clk;

endmodule

// File: tb/tb_baud_generator.sv
// Directed bench for baud_generator with DIVISOR = 16 (HALF = 8).
module tb_baud_generator;

  logic clk;
  logic i_reset;
  logic i_enable;
  logic i_start;
  logic o_status;
  logic o_finish;
  logic o_baud_clk;

  int   cyc;
  int   n_cmp;
  int   n_err;
  int   overlap;
  int   t0;
  int   gap;
  int   ofs;
  int   baud_q[$];
  int   finish_q[$];
  logic [7:0] rx_reg;

  baud_generator #(
    .CLK_FREQ (16),
    .BAUD     (1)
  ) dut (
    .i_sysclk   (clk),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_start    (i_start),
    .o_status   (o_status),
    .o_finish   (o_finish),
    .o_baud_clk (o_baud_clk)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model: shift the RX line (LSB first) on each strobe.
  initial begin
    rx_reg  = 8'h00;
    overlap = 0;
  end

  always @(negedge clk) begin
    if (o_baud_clk) begin
      baud_q.push_back(cyc);
      rx_reg <= {~i_start, rx_reg[7:1]};
    end
    if (o_finish) finish_q.push_back(cyc);
    if (o_baud_clk && o_finish) overlap <= overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drives a frame from the current negedge: start bit, 8 data bits, stop bit.
  task automatic send_frame(input logic [7:0] d, input int ncyc, input bit stop_low);
    int b;
    for (int n = 0; n < ncyc; n++) begin
      b = n / 16;
      if (b == 0)      i_start = 1'b1;
      else if (b <= 8) i_start = ~d[b-1];
      else             i_start = stop_low;
      @(negedge clk);
    end
  endtask

  task automatic clear_obs();
    baud_q.delete();
    finish_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    i_reset  = 1'b1;
    i_enable = 1'b1;
    i_start  = 1'b0;

    // 1: reset held with start toggling
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_start = ~i_start;
      chk("reset_outputs", {29'd0, o_status, o_finish, o_baud_clk}, 32'd0);
    end
    i_start = 1'b0;
    @(negedge clk);
    i_reset = 1'b0;
    repeat (4) @(negedge clk);

    // 2: frame 0xA5; first strobe = 2 sync + 1 FSM register + HALF + DIVISOR = 27
    clear_obs();
    t0 = cyc;
    send_frame(8'hA5, 160, 1'b0);
    chk("a5_strobe_count", baud_q.size(), 8);
    ofs = (baud_q.size() > 0) ? baud_q[0] - t0 : -1;
    chk("a5_first_strobe_ofs", ofs, 27);
    for (int k = 1; k < 8; k++) begin
      gap = (baud_q.size() > k) ? baud_q[k] - baud_q[k-1] : -1;
      chk("a5_strobe_gap", gap, 16);
    end
    chk("a5_rx_data", {24'd0, rx_reg}, 32'hA5);
    chk("a5_finish_count", finish_q.size(), 1);
    ofs = (finish_q.size() > 0 && baud_q.size() == 8) ? finish_q[0] - baud_q[7] : -1;
    chk("a5_finish_after_last", ofs, 16);
    chk("a5_status_end", {31'd0, o_status}, 0);

    // 3: 4-cycle glitch is rejected at the half-bit check
    clear_obs();
    i_start = 1'b1;
    repeat (4) @(negedge clk);
    i_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("glitch_status_high", {31'd0, o_status}, 1);
    repeat (6) @(negedge clk);
    chk("glitch_status_low", {31'd0, o_status}, 0);
    repeat (40) @(negedge clk);
    chk("glitch_no_strobe", baud_q.size(), 0);
    chk("glitch_no_finish", finish_q.size(), 0);

    // 4: enable dropped after 3 strobes, then a clean 0x3C frame
    clear_obs();
    send_frame(8'h5A, 64, 1'b0);
    i_enable = 1'b0;
    @(negedge clk);
    chk("disable_status", {31'd0, o_status}, 0);
    chk("disable_strobes", baud_q.size(), 3);
    i_start = 1'b0;
    repeat (40) @(negedge clk);
    chk("disabled_no_strobe", baud_q.size(), 3);
    chk("disabled_no_finish", finish_q.size(), 0);
    chk("disabled_status", {31'd0, o_status}, 0);
    i_enable = 1'b1;
    repeat (4) @(negedge clk);
    clear_obs();
    send_frame(8'h3C, 160, 1'b0);
    chk("3c_rx_data", {24'd0, rx_reg}, 32'h3C);
    chk("3c_strobe_count", baud_q.size(), 8);
    chk("3c_finish_count", finish_q.size(), 1);

    // 5: back-to-back 0x00 then 0xFF with a single stop bit
    clear_obs();
    send_frame(8'h00, 160, 1'b0);
    chk("b2b_rx_00", {24'd0, rx_reg}, 32'h00);
    chk("b2b_finish_1", finish_q.size(), 1);
    send_frame(8'hFF, 160, 1'b0);
    chk("b2b_rx_ff", {24'd0, rx_reg}, 32'hFF);
    chk("b2b_strobe_count", baud_q.size(), 16);
    chk("b2b_finish_2", finish_q.size(), 2);

    // 6: break (line held low through and after the frame)
    clear_obs();
    send_frame(8'h00, 160, 1'b1);
    repeat (100) @(negedge clk);
    chk("break_strobe_count", baud_q.size(), 8);
    chk("break_finish_count", finish_q.size(), 1);
    chk("break_status", {31'd0, o_status}, 0);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    clear_obs();
    send_frame(8'h96, 160, 1'b0);
    chk("after_break_rx", {24'd0, rx_reg}, 32'h96);
    chk("after_break_strobes", baud_q.size(), 8);
    chk("after_break_finish", finish_q.size(), 1);

    chk("finish_baud_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
